// File: rtl/cu_read_command_arbiter_rr.sv
// Round-robin arbiter sharing the read-command path into the AFU command buffer,
// with burst hold, an in-flight grant cap and a registered merge of returned commands.
package cu_read_command_arbiter_rr_pkg;

  localparam int CMD_PAYLOAD_W = 32;

  typedef struct packed {
    logic full;
    logic alfull;
  } BufferStatus;

  typedef struct packed {
    logic                     valid;
    logic [CMD_PAYLOAD_W-1:0] payload;
  } CommandBufferLine;

endpackage

module cu_read_command_arbiter_rr
  import cu_read_command_arbiter_rr_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 2,
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                 clock,
  input  logic                 rst_in,
  input  logic                 enabled_in,
  input  BufferStatus          cmd_buffer_status_in,
  input  logic [NUM_REQ-1:0]   request_in,
  output logic [NUM_REQ-1:0]   grant_out,
  input  CommandBufferLine     command_in [NUM_REQ],
  output CommandBufferLine     command_out,
  output logic [CNT_W-1:0]     inflight_count_out,
  output logic                 error_out
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1);

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  arb_state_e                arb_state_q;
  logic [IDX_W-1:0]          pointer_q;
  logic [IDX_W-1:0]          last_idx_q;
  logic [BURST_W-1:0]        burst_cnt_q;
  logic [NUM_REQ-1:0]        grant_q;
  logic [CNT_W-1:0]          inflight_q;
  logic                      error_q;
  logic                      post_reset_q;
  logic                      cmd_valid_q;
  logic [CMD_PAYLOAD_W-1:0]  cmd_payload_q;

  logic                      grant_eligible;
  logic                      burst_continue;
  logic                      rr_found;
  logic [IDX_W-1:0]          rr_idx;
  logic [IDX_W-1:0]          rr_winner;
  logic [IDX_W-1:0]          rr_next_ptr;
  logic                      lane_hit;
  logic                      lane_multi;
  logic [CMD_PAYLOAD_W-1:0]  lane_payload;
  logic                      cmd_dec;
  logic                      cmd_orphan;
  logic                      unused_status;

  assign unused_status = cmd_buffer_status_in.full;

  assign grant_eligible = enabled_in && !cmd_buffer_status_in.alfull &&
                          (inflight_q < CNT_W'(MAX_INFLIGHT)) && (|request_in);

  assign burst_continue = (arb_state_q == ARB_BURST) && request_in[last_idx_q] &&
                          (burst_cnt_q < BURST_W'(MAX_BURST));

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    rr_found  = 1'b0;
    rr_idx    = '0;
    rr_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = IDX_W'((int'(pointer_q) + k) % NUM_REQ);
      if (!rr_found && request_in[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx;
      end
    end
    rr_next_ptr = IDX_W'((int'(rr_winner) + 1) % NUM_REQ);
  end

  always_comb begin
    lane_hit     = 1'b0;
    lane_multi   = 1'b0;
    lane_payload = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (command_in[k].valid) begin
        if (lane_hit) begin
          lane_multi = 1'b1;
        end else begin
          lane_payload = command_in[k].payload;
        end
        lane_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst_in) begin
      arb_state_q <= ARB_IDLE;
      pointer_q   <= '0;
      last_idx_q  <= '0;
      burst_cnt_q <= '0;
      grant_q     <= '0;
    end else if (!grant_eligible) begin
      arb_state_q <= ARB_IDLE;
      burst_cnt_q <= '0;
      grant_q     <= '0;
    end else if (burst_continue) begin
      burst_cnt_q <= burst_cnt_q + BURST_W'(1);
      grant_q     <= GRANT_ONE << last_idx_q;
    end else begin
      arb_state_q <= ARB_BURST;
      last_idx_q  <= rr_winner;
      pointer_q   <= rr_next_ptr;
      burst_cnt_q <= BURST_W'(1);
      grant_q     <= GRANT_ONE << rr_winner;
    end
  end

  // Commands still in flight across a reset return while the counter sits at
  // zero; they are tolerated until the first new grant after reset.
  assign cmd_dec    = lane_hit && (inflight_q != '0);
  assign cmd_orphan = lane_hit && (inflight_q == '0) && !post_reset_q;

  always_ff @(posedge clock) begin
    if (rst_in) begin
      inflight_q   <= '0;
      error_q      <= 1'b0;
      post_reset_q <= 1'b1;
      cmd_valid_q  <= 1'b0;
    end else begin
      cmd_valid_q <= lane_hit;
      if (grant_eligible && !cmd_dec) begin
        inflight_q <= inflight_q + CNT_W'(1);
      end else if (!grant_eligible && cmd_dec) begin
        inflight_q <= inflight_q - CNT_W'(1);
      end
      if (lane_multi || cmd_orphan) begin
        error_q <= 1'b1;
      end
      if (grant_eligible) begin
        post_reset_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (lane_hit) begin
      cmd_payload_q <= lane_payload;
    end
  end

  assign grant_out          = grant_q;
  assign command_out        = {cmd_valid_q, cmd_payload_q};
  assign inflight_count_out = inflight_q;
  assign error_out          = error_q;

endmodule

// File: tb/tb_cu_read_command_arbiter_rr.sv
// Randomized and directed bench for cu_read_command_arbiter_rr, checked every
// cycle against a behavioural arbiter model kept in plain integers.
module tb_cu_read_command_arbiter_rr;
  import cu_read_command_arbiter_rr_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int MAX_BURST    = 2;
  localparam int MAX_INFLIGHT = 8;
  localparam int CNT_W        = 4;

  logic                clock = 1'b0;
  logic                rst_in;
  logic                enabled_in;
  BufferStatus         cmd_buffer_status_in;
  logic [NUM_REQ-1:0]  request_in;
  logic [NUM_REQ-1:0]  grant_out;
  CommandBufferLine    command_in [NUM_REQ];
  CommandBufferLine    command_out;
  logic [CNT_W-1:0]    inflight_count_out;
  logic                error_out;

  cu_read_command_arbiter_rr #(
    .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .rst_in(rst_in),
    .enabled_in(enabled_in),
    .cmd_buffer_status_in(cmd_buffer_status_in),
    .request_in(request_in),
    .grant_out(grant_out),
    .command_in(command_in),
    .command_out(command_out),
    .inflight_count_out(inflight_count_out),
    .error_out(error_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int retLane[$];
  int retDue[$];

  // Reference model state: arbitration expressed directly as pointer/burst rules.
  int m_ptr, m_last, m_burst, m_inflight, m_win;
  bit m_active, m_err, m_window, m_ready, m_cvalid;
  logic [NUM_REQ-1:0] m_grant;
  logic [CMD_PAYLOAD_W-1:0] m_payload;

  int vcount, gcount;
  logic [CMD_PAYLOAD_W-1:0] saved;
  logic [NUM_REQ-1:0] oneBase;
  int expSeq[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
  endtask

  function automatic void modelStep();
    int nvalid, first, c;
    bit eligible;
    nvalid = 0;
    first  = -1;
    m_win  = -1;
    if (rst_in) begin
      m_ptr = 0; m_last = 0; m_burst = 0; m_inflight = 0;
      m_active = 0; m_err = 0; m_window = 1; m_cvalid = 0;
      m_grant = '0; m_ready = 1;
      return;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (command_in[k].valid) begin
        nvalid++;
        if (first < 0) first = k;
      end
    end
    eligible = enabled_in && !cmd_buffer_status_in.alfull &&
               (m_inflight < MAX_INFLIGHT) && (request_in != '0);
    if (nvalid > 1 || (nvalid > 0 && m_inflight == 0 && !m_window)) m_err = 1;
    if (eligible) begin
      if (m_active && request_in[m_last] && m_burst < MAX_BURST) begin
        m_win = m_last;
        m_burst++;
      end else begin
        for (int off = 0; off < NUM_REQ; off++) begin
          c = (m_ptr + off) % NUM_REQ;
          if (m_win < 0 && request_in[c]) m_win = c;
        end
        m_ptr    = (m_win + 1) % NUM_REQ;
        m_burst  = 1;
        m_last   = m_win;
        m_active = 1;
      end
      m_window = 0;
    end else begin
      m_active = 0;
      m_burst  = 0;
    end
    m_inflight = m_inflight + (eligible ? 1 : 0) - ((nvalid > 0 && m_inflight > 0) ? 1 : 0);
    m_grant = eligible ? (NUM_REQ'(1) << m_win) : '0;
    m_cvalid = (nvalid > 0);
    if (nvalid > 0) m_payload = command_in[first].payload;
  endfunction

  task automatic checkAll();
    if (m_ready) begin
      checkOutput("grant", grant_out, m_grant);
      checkOutput("cmd_valid", command_out.valid, m_cvalid);
      if (m_cvalid) checkOutput("cmd_payload", command_out.payload, m_payload);
      checkOutput("inflight", inflight_count_out, m_inflight);
      checkOutput("error", error_out, m_err);
    end
  endtask

  // One cycle: check the previous edge's outputs, then drive the next inputs.
  // Granted requesters return their command lat cycles later (lat<0: random).
  task automatic applyStimulus(input logic rst, input logic en, input logic af,
                               input logic [NUM_REQ-1:0] req, input bit holdRet,
                               input int lat, input logic [NUM_REQ-1:0] forceLanes);
    int delay;
    bit done;
    @(negedge clock);
    checkAll();
    rst_in = rst;
    enabled_in = en;
    cmd_buffer_status_in.alfull = af;
    cmd_buffer_status_in.full = 1'b0;
    request_in = req;
    for (int k = 0; k < NUM_REQ; k++) begin
      command_in[k].valid = 1'b0;
      command_in[k].payload = $urandom;
    end
    if (forceLanes != '0) begin
      for (int k = 0; k < NUM_REQ; k++) if (forceLanes[k]) command_in[k].valid = 1'b1;
    end else if (!holdRet) begin
      done = 0;
      for (int i = 0; i < retDue.size(); i++) begin
        if (!done && retDue[i] <= cyc) begin
          command_in[retLane[i]].valid = 1'b1;
          retLane.delete(i);
          retDue.delete(i);
          done = 1;
        end
      end
    end
    modelStep();
    if (m_win >= 0) begin
      delay = (lat < 0) ? int'($urandom_range(1, 5)) : lat;
      retLane.push_back(m_win);
      retDue.push_back(cyc + 1 + delay);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1, '0);
  endtask

  task automatic doReset();
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1, 1, '0);
  endtask

  task automatic randomPhase(input int n);
    for (int j = 0; j < n; j++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 7) == 0), NUM_REQ'($urandom),
                    ($urandom_range(0, 3) == 0), -1,
                    ($urandom_range(0, 49) == 0) ? NUM_REQ'($urandom) : NUM_REQ'(0));
    end
  endtask

  initial begin
    rst_in = 1'b1;
    enabled_in = 1'b0;
    cmd_buffer_status_in = '0;
    request_in = '0;
    for (int k = 0; k < NUM_REQ; k++) command_in[k] = '0;
    oneBase = NUM_REQ'(1);
    m_ready = 0;

    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1, 1, '0);

    // All requesting, commands back after the grant: burst-of-two rotation.
    for (int j = 0; j < 14; j++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 2, '0);
      if (j >= 1 && j <= 10) checkOutput("rr_order", grant_out, oneBase << expSeq[j-1]);
    end
    checkOutput("steady_inflight", inflight_count_out, 3);

    // Almost-full blocks grants while pending commands drain.
    vcount = 0;
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 2, '0);
      if (j >= 1) begin
        checkOutput("alfull_nogrant", grant_out, 0);
        if (command_out.valid) vcount++;
      end
    end
    checkOutput("alfull_drained", vcount, 3);
    checkOutput("alfull_inflight", inflight_count_out, 0);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 2, '0);

    // Single requester is granted every cycle across burst boundaries.
    for (int j = 0; j < 12; j++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 2, '0);
      if (j >= 1) checkOutput("solo_grant", grant_out, 4'b0100);
    end
    idle(12);

    randomPhase(400);
    doReset();
    idle(40);
    retLane.delete();
    retDue.delete();

    // Saturate the in-flight cap, then free exactly one slot.
    doReset();
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1, '0);
    checkOutput("sat_inflight", inflight_count_out, MAX_INFLIGHT);
    checkOutput("sat_nogrant", grant_out, 0);
    gcount = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1, '0);
    gcount += $countones(grant_out);
    repeat (4) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1, '0);
      gcount += $countones(grant_out);
    end
    checkOutput("one_more_grant", gcount, 1);
    checkOutput("resat_inflight", inflight_count_out, MAX_INFLIGHT);
    idle(20);

    // Reset with five commands outstanding; they return afterwards harmlessly.
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1, '0);
    checkOutput("pre_reset_inflight", inflight_count_out, 5);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1, '0);
    checkOutput("rst_grant", grant_out, 0);
    checkOutput("rst_inflight", inflight_count_out, 0);
    checkOutput("rst_error", error_out, 0);
    vcount = 0;
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1, '0);
      if (command_out.valid) vcount++;
    end
    checkOutput("stale_forwarded", vcount, 5);
    checkOutput("stale_no_error", error_out, 0);
    checkOutput("stale_inflight", inflight_count_out, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 2, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 2, '0);
    checkOutput("post_reset_first", grant_out, 4'b0001);
    idle(10);

    // Two lanes valid together: lowest lane wins, error sticks.
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1, 4'b1010);
    saved = command_in[1].payload;
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1, '0);
    checkOutput("multi_payload", command_out.payload, saved);
    checkOutput("multi_valid", command_out.valid, 1);
    checkOutput("multi_error", error_out, 1);
    checkOutput("multi_inflight", inflight_count_out, 2);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1, '0);
    checkOutput("error_sticky", error_out, 1);
    doReset();
    idle(10);

    // A command with nothing outstanding, after normal traffic, is an error.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 1, '0);
    idle(6);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1, 4'b0001);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1, '0);
    checkOutput("orphan_error", error_out, 1);
    checkOutput("orphan_inflight", inflight_count_out, 0);
    doReset();

    randomPhase(300);
    @(negedge clock);
    checkAll();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
